// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: PC source select, jump class and FSM states.
// The pcsrc_t encoding is decoded by program_counter, so the two must stay in step.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        PC_JR  = 2'd0,
        PC_J   = 2'd1,
        PC_BR  = 2'd2,
        PC_SEQ = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        JT_NONE = 2'd0,
        JT_JR   = 2'd1,
        JT_J    = 2'd2,
        JT_BR   = 2'd3
    } jtype_t;

    typedef enum logic [1:0] {
        IFETCH = 2'd0,
        DMEM   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // A not-taken branch falls through to PC+4 like any non-jump.
    function automatic pcsrc_t decode_pcsrc(input jtype_t jt, input logic br_taken);
        pcsrc_t src;
        src = PC_SEQ;
        case (jt)
            JT_JR:   src = PC_JR;
            JT_J:    src = PC_J;
            JT_BR:   src = br_taken ? PC_BR : PC_SEQ;
            default: src = PC_SEQ;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_hit_watchdog.sv
// Counts consecutive cycles spent waiting on a memory hit and raises a sticky
// flag once a wait has lasted TIMEOUT_CYCLES.
module hit_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic wait_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;
    logic          expired_q, expired_d;

    // The counter parks at LAST instead of wrapping; the flag stays set until reset.
    always_comb begin
        count_d   = count_q;
        expired_d = expired_q;
        if (clr) begin
            count_d = '0;
        end else if (wait_en) begin
            if (count_q == LAST) begin
                expired_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Drives the PC update strobe and source select, and gates I/D memory requests
// so the PC advances exactly once per retired instruction.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       ctr_dREN,
    input  logic       ctr_dWEN,
    input  logic       halt,
    input  logic [1:0] jtype,
    input  logic       br_taken,
    output logic       pc_en,
    output logic [1:0] PCSrc,
    output logic       imemREN,
    output logic       dmemREN,
    output logic       dmemWEN,
    output logic       halted,
    output logic       mem_timeout
);

    fetch_state_t state_q, state_d;
    logic         dren_q, dren_d;
    logic         dwen_q, dwen_d;
    pcsrc_t       pc_src;
    logic         hit_now;
    logic         wd_clr;
    logic         wd_wait;

    always_comb begin
        state_d = state_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        pc_en   = 1'b0;
        pc_src  = decode_pcsrc(jtype_t'(jtype), br_taken);
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        hit_now = 1'b0;
        case (state_q)
            IFETCH: begin
                imemREN = 1'b1;
                hit_now = ihit;
                if (ihit) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (ctr_dREN || ctr_dWEN) begin
                        dren_d  = ctr_dREN;
                        dwen_d  = ctr_dWEN;
                        state_d = DMEM;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            DMEM: begin
                // Both strobes pass through unmasked so a bad decode is visible downstream.
                dmemREN = dren_q;
                dmemWEN = dwen_q;
                pc_src  = PC_SEQ;
                hit_now = dhit;
                if (dhit) begin
                    pc_en   = 1'b1;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    state_d = IFETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IFETCH;
            end
        endcase
        wd_clr  = hit_now || (state_d != state_q) || (state_q == HALTED);
        wd_wait = (state_q != HALTED);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IFETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
        end
    end

    hit_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_hit_watchdog (
        .CLK    (CLK),
        .nRST   (nRST),
        .clr    (wd_clr),
        .wait_en(wd_wait),
        .expired(mem_timeout)
    );

    assign PCSrc  = pc_src;
    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Table-driven check of the fetch sequencer, one vector per clock, with expected
// outputs queued as each vector is driven and popped when the outputs are sampled.
module tb_pc_fetch_sequencer;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pcsrc;
        logic       imem;
        logic       dren;
        logic       dwen;
        logic       halted;
        logic       timeout;
    } exp_t;

    typedef struct packed {
        logic       nrst;
        logic       ihit;
        logic       dhit;
        logic       dren;
        logic       dwen;
        logic       halt;
        logic [1:0] jtype;
        logic       br;
        exp_t       exp;
    } vec_t;

    logic       clk;
    logic       nrst;
    logic       ihit;
    logic       dhit;
    logic       ctr_dren;
    logic       ctr_dwen;
    logic       halt;
    logic [1:0] jtype;
    logic       br_taken;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       imem_ren;
    logic       dmem_ren;
    logic       dmem_wen;
    logic       halted;
    logic       mem_timeout;

    exp_t exp_q[$];
    vec_t table_q[$];
    int   vec_count = 0;
    int   miss_count = 0;

    pc_fetch_sequencer #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK        (clk),
        .nRST       (nrst),
        .ihit       (ihit),
        .dhit       (dhit),
        .ctr_dREN   (ctr_dren),
        .ctr_dWEN   (ctr_dwen),
        .halt       (halt),
        .jtype      (jtype),
        .br_taken   (br_taken),
        .pc_en      (pc_en),
        .PCSrc      (pc_src),
        .imemREN    (imem_ren),
        .dmemREN    (dmem_ren),
        .dmemWEN    (dmem_wen),
        .halted     (halted),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(
        input logic n, input logic i, input logic d, input logic r, input logic w,
        input logic h, input logic [1:0] j, input logic b,
        input logic p, input logic [1:0] s, input logic im, input logic dr,
        input logic dw, input logic hl, input logic to);
        vec_t v;
        v.nrst  = n;  v.ihit = i;  v.dhit = d;  v.dren = r;  v.dwen = w;
        v.halt  = h;  v.jtype = j; v.br = b;
        v.exp.pc_en  = p;  v.exp.pcsrc = s;  v.exp.imem = im;
        v.exp.dren   = dr; v.exp.dwen  = dw; v.exp.halted = hl; v.exp.timeout = to;
        return v;
    endfunction

    task automatic checkOutput(input string name);
        exp_t e;
        exp_t act;
        act = {pc_en, pc_src, imem_ren, dmem_ren, dmem_wen, halted, mem_timeout};
        vec_count++;
        if (exp_q.size() == 0) begin
            miss_count++;
            $display("[TB] FAIL %s: scoreboard empty, got %b", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                miss_count++;
                $display("[TB] FAIL %s: got pc_en/src/imem/dren/dwen/halted/to=%b required %b",
                         name, act, e);
            end
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled shortly after, well before the rising edge.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        nrst     = v.nrst;
        ihit     = v.ihit;
        dhit     = v.dhit;
        ctr_dren = v.dren;
        ctr_dwen = v.dwen;
        halt     = v.halt;
        jtype    = v.jtype;
        br_taken = v.br;
        exp_q.push_back(v.exp);
        #2;
        checkOutput(name);
    endtask

    initial begin
        nrst = 1'b0; ihit = 1'b0; dhit = 1'b0; ctr_dren = 1'b0; ctr_dwen = 1'b0;
        halt = 1'b0; jtype = 2'd0; br_taken = 1'b0;
        repeat (3) @(posedge clk);

        //                 n i d r w h j b   p s im dr dw hl to
        table_q.push_back(mkv(1,0,0,0,0,0,0,0, 0,3,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,0,0,0,0,0, 1,3,1,0,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0,0,0,0, 0,3,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,0,0,0,3,1, 1,2,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,0,0,0,3,0, 1,3,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,0,0,0,1,0, 1,0,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,0,0,0,2,0, 1,1,1,0,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0,0,3,1, 0,2,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,1,0,0,0,0, 0,3,1,0,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0,0,0,0, 0,3,0,1,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0,0,0,0, 0,3,0,1,0,0,0));
        table_q.push_back(mkv(1,1,0,0,0,0,1,0, 0,3,0,1,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0,0,0,0, 0,3,0,1,0,0,0));
        table_q.push_back(mkv(1,0,1,0,0,0,0,0, 1,3,0,1,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0,0,0,0, 0,3,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,1,1,0,0,0, 0,3,1,0,0,0,0));
        table_q.push_back(mkv(1,0,1,0,0,0,0,0, 1,3,0,1,1,0,0));
        table_q.push_back(mkv(1,1,0,0,1,0,0,0, 0,3,1,0,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0,0,0,0, 0,3,0,0,1,0,0));
        table_q.push_back(mkv(1,0,1,0,0,0,2,0, 1,3,0,0,1,0,0));
        table_q.push_back(mkv(1,1,0,0,0,0,0,0, 1,3,1,0,0,0,0));
        table_q.push_back(mkv(1,1,0,0,1,1,2,0, 0,1,1,0,0,0,0));

        for (int k = 0; k < table_q.size(); k++) begin
            applyStimulus(table_q[k], $sformatf("table[%0d]", k));
        end

        // Halted must ignore every request input for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(mkv(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                              1'($urandom), 0, 0, 0,3,0,0,0,1,0), $sformatf("halted[%0d]", k));
        end
        applyStimulus(mkv(0,0,0,0,0,0,0,0, 0,3,0,0,0,1,0), "halt_reset");
        applyStimulus(mkv(1,0,0,0,0,0,0,0, 0,3,1,0,0,0,0), "after_halt_reset");

        // Load that never completes: flag rises after 8 waiting cycles, then a reset drops it.
        applyStimulus(mkv(1,1,0,1,0,0,0,0, 0,3,1,0,0,0,0), "to_enter_dmem");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(mkv(1,0,0,0,0,0,0,0, 0,3,0,1,0,0,0), $sformatf("to_wait[%0d]", k));
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mkv(1,0,0,0,0,0,0,0, 0,3,0,1,0,0,1), $sformatf("to_set[%0d]", k));
        end
        applyStimulus(mkv(0,0,0,0,0,0,0,0, 0,3,0,1,0,0,1), "to_reset");
        applyStimulus(mkv(1,0,0,0,0,0,0,0, 0,3,1,0,0,0,0), "after_to_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
